// File: rtl/eth_tx_pkg.sv
`default_nettype none
//============================================================================
// eth_tx_pkg : shared types and helpers for the 10GE transmit packet feeder
// Rev 1.0
//============================================================================
package eth_tx_pkg;

  localparam int ETH_DATA_W = 64;
  localparam int ETH_MOD_W  = 3;
  localparam int ETH_KEEP_W = ETH_DATA_W / 8;

  typedef struct packed {
    logic [ETH_DATA_W-1:0] data;
    logic                  last;
    logic [ETH_MOD_W-1:0]  mod;
  } eth_tx_word_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } tx_fsm_e;

  typedef struct packed {
    logic                 legal;
    logic [ETH_MOD_W-1:0] mod;
  } keep_mod_t;

  // A legal mask is non-zero and LSB-contiguous, i.e. keep+1 clears every set bit.
  function automatic keep_mod_t keep_to_mod(input logic [ETH_KEEP_W-1:0] keep);
    keep_mod_t r;
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < ETH_KEEP_W; i++) begin
      ones = ones + {3'b000, keep[i]};
    end
    r.legal = (keep != '0) && ((keep & (keep + 8'h01)) == '0);
    r.mod   = r.legal ? ones[ETH_MOD_W-1:0] : '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_sync_fifo.sv
`default_nettype none
//============================================================================
// eth_tx_sync_fifo : single-clock word FIFO with extra-MSB pointers
// Rev 1.0
//============================================================================
module eth_tx_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 68
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_pkt_feeder.sv
`default_nettype none
//============================================================================
// eth_tx_pkt_feeder : buffers stream beats and feeds the 10GE MAC tx port
// Rev 1.0
//============================================================================
module eth_tx_pkt_feeder
  import eth_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ETH_DATA_W-1:0] s_data,
  input  logic [ETH_KEEP_W-1:0] s_keep,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ETH_DATA_W-1:0] pkt_tx_data,
  output logic                  pkt_tx_val,
  output logic                  pkt_tx_sop,
  output logic                  pkt_tx_eop,
  output logic [ETH_MOD_W-1:0]  pkt_tx_mod,
  input  logic                  pkt_tx_full,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      keep_err_cnt
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          WORD_W    = $bits(eth_tx_word_t);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  eth_tx_word_t push_word;
  eth_tx_word_t head_word;
  keep_mod_t    keep_info;
  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;

  tx_fsm_e               state_q, state_d;
  logic [ETH_DATA_W-1:0] data_q, data_d;
  logic                  val_q, val_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [ETH_MOD_W-1:0]  mod_q, mod_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]      keep_err_cnt_q, keep_err_cnt_d;

  // Held low while rst is asserted so no beat is taken during reset.
  assign s_ready = ~rst & (fifo_count < DEPTH_CNT);
  assign push    = s_valid & s_ready & ~fifo_full;
  assign pop     = ~fifo_empty & ~pkt_tx_full;

  assign keep_info      = keep_to_mod(s_keep);
  assign push_word.data = s_data;
  assign push_word.last = s_last;
  assign push_word.mod  = s_last ? keep_info.mod : '0;

  eth_tx_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    val_d          = pop;
    sop_d          = 1'b0;
    eop_d          = 1'b0;
    mod_d          = '0;
    pkt_cnt_d      = pkt_cnt_q + {{(CNT_W-1){1'b0}}, (val_q & eop_q)};
    keep_err_cnt_d = keep_err_cnt_q +
                     {{(CNT_W-1){1'b0}}, (push & s_last & ~keep_info.legal)};
    if (pop) begin
      data_d = head_word.data;
      eop_d  = head_word.last;
      mod_d  = head_word.last ? head_word.mod : '0;
      case (state_q)
        IDLE: begin
          sop_d = 1'b1;
          if (!head_word.last) begin
            state_d = IN_PKT;
          end
        end
        IN_PKT: begin
          if (head_word.last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      data_q         <= '0;
      val_q          <= 1'b0;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
      mod_q          <= '0;
      pkt_cnt_q      <= '0;
      keep_err_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      val_q          <= val_d;
      sop_q          <= sop_d;
      eop_q          <= eop_d;
      mod_q          <= mod_d;
      pkt_cnt_q      <= pkt_cnt_d;
      keep_err_cnt_q <= keep_err_cnt_d;
    end
  end

  assign pkt_tx_data  = data_q;
  assign pkt_tx_val   = val_q;
  assign pkt_tx_sop   = sop_q;
  assign pkt_tx_eop   = eop_q;
  assign pkt_tx_mod   = mod_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign keep_err_cnt = keep_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_pkt_feeder.sv
`default_nettype none
//============================================================================
// tb_eth_tx_pkt_feeder : directed self-checking bench for eth_tx_pkt_feeder
// Rev 1.0
//============================================================================
module tb_eth_tx_pkt_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_full;
  logic [31:0] pkt_cnt;
  logic [31:0] keep_err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    int          cyc;
  } obs_t;
  obs_t obs[$];

  eth_tx_pkt_feeder #(.DEPTH(16), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_keep       (s_keep),
    .s_last       (s_last),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .pkt_tx_data  (pkt_tx_data),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .pkt_tx_mod   (pkt_tx_mod),
    .pkt_tx_full  (pkt_tx_full),
    .pkt_cnt      (pkt_cnt),
    .keep_err_cnt (keep_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every word the MAC would take.
  always @(negedge clk) begin
    if (pkt_tx_val) begin
      obs.push_back('{d: pkt_tx_data, sop: pkt_tx_sop, eop: pkt_tx_eop,
                      mod: pkt_tx_mod, cyc: cyc});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic last);
    int guard;
    guard   = 0;
    s_data  = d;
    s_keep  = k;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: observed s_ready 0 expected 1 within 300 cycles");
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst         = 1'b1;
    s_data      = '0;
    s_keep      = '0;
    s_last      = 1'b0;
    s_valid     = 1'b0;
    pkt_tx_full = 1'b0;
    idle(3);

    // Reset state
    chk("rst_s_ready", s_ready, 0);
    chk("rst_val", pkt_tx_val, 0);
    chk("rst_data", pkt_tx_data, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_keep_err", keep_err_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    tick();

    // Single-word packet, keep 0x0F: two-cycle latency, mod 4
    push_beat(64'h1122_3344_5566_7788, 8'h0F, 1'b1);
    chk("p1_val_early", pkt_tx_val, 0);
    tick();
    chk("p1_val", pkt_tx_val, 1);
    chk("p1_sop", pkt_tx_sop, 1);
    chk("p1_eop", pkt_tx_eop, 1);
    chk("p1_mod", pkt_tx_mod, 4);
    chk("p1_data", pkt_tx_data, 64'h1122_3344_5566_7788);
    chk("p1_cnt_before", pkt_cnt, 0);
    tick();
    chk("p1_val_off", pkt_tx_val, 0);
    chk("p1_sop_off", pkt_tx_sop, 0);
    chk("p1_eop_off", pkt_tx_eop, 0);
    chk("p1_data_hold", pkt_tx_data, 64'h1122_3344_5566_7788);
    chk("p1_pkt_cnt", pkt_cnt, 1);
    idle(3);

    // Five-word packet, last keep 0xFF -> mod 0, back-to-back output
    obs.delete();
    for (int i = 0; i < 5; i++) push_beat(64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, i == 4);
    idle(6);
    chk("p5_words", obs.size(), 5);
    if (obs.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("p5_data%0d", i), obs[i].d, 64'hA5A5_0000_0000_0000 + 64'(i));
        chk($sformatf("p5_sop%0d", i), obs[i].sop, (i == 0) ? 1 : 0);
        chk($sformatf("p5_eop%0d", i), obs[i].eop, (i == 4) ? 1 : 0);
      end
      chk("p5_mod", obs[4].mod, 0);
      chk("p5_contig", obs[4].cyc - obs[0].cyc, 4);
    end
    chk("p5_pkt_cnt", pkt_cnt, 2);

    // Three-word packet with MAC back-pressure after the first output word
    obs.delete();
    push_beat(64'hC000_0000_0000_0000, 8'hFF, 1'b0);
    push_beat(64'hC000_0000_0000_0001, 8'hFF, 1'b0);
    chk("p3_first_out", pkt_tx_val, 1);
    pkt_tx_full = 1'b1;
    push_beat(64'hC000_0000_0000_0002, 8'h3F, 1'b1);
    chk("p3_stall0", pkt_tx_val, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("p3_stall%0d", i), pkt_tx_val, 0);
    end
    pkt_tx_full = 1'b0;
    idle(5);
    chk("p3_words", obs.size(), 3);
    if (obs.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("p3_data%0d", i), obs[i].d, 64'hC000_0000_0000_0000 + 64'(i));
        chk($sformatf("p3_sop%0d", i), obs[i].sop, (i == 0) ? 1 : 0);
        chk($sformatf("p3_eop%0d", i), obs[i].eop, (i == 2) ? 1 : 0);
      end
      chk("p3_mod", obs[2].mod, 6);
    end
    chk("p3_pkt_cnt", pkt_cnt, 3);

    // Fill the FIFO while the MAC is full; the 17th beat must wait
    obs.delete();
    pkt_tx_full = 1'b1;
    for (int i = 0; i < 16; i++) push_beat(64'hF000_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
    chk("fill_ready_low", s_ready, 0);
    s_data  = 64'hF000_0000_0000_0010;
    s_keep  = 8'h01;
    s_last  = 1'b1;
    s_valid = 1'b1;
    idle(3);
    chk("fill_still_held", s_ready, 0);
    chk("fill_no_val", pkt_tx_val, 0);
    pkt_tx_full = 1'b0;
    push_beat(64'hF000_0000_0000_0010, 8'h01, 1'b1);
    idle(25);
    chk("fill_words", obs.size(), 17);
    if (obs.size() == 17) begin
      for (int i = 0; i < 17; i++) begin
        chk($sformatf("fill_data%0d", i), obs[i].d, 64'hF000_0000_0000_0000 + 64'(i));
      end
      chk("fill_sop", obs[0].sop, 1);
      chk("fill_eop_mid", obs[15].eop, 0);
      chk("fill_eop", obs[16].eop, 1);
      chk("fill_mod", obs[16].mod, 1);
    end
    chk("fill_pkt_cnt", pkt_cnt, 4);

    // Non-contiguous keep: only the last beat's mask counts as an error
    obs.delete();
    push_beat(64'hE000_0000_0000_0000, 8'h05, 1'b0);
    push_beat(64'hE000_0000_0000_0001, 8'h05, 1'b1);
    idle(4);
    chk("kerr_cnt", keep_err_cnt, 1);
    chk("kerr_words", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("kerr_eop", obs[1].eop, 1);
      chk("kerr_mod", obs[1].mod, 0);
    end
    chk("kerr_pkt_cnt", pkt_cnt, 5);

    // Reset during a four-word packet
    push_beat(64'hD000_0000_0000_0000, 8'hFF, 1'b0);
    push_beat(64'hD000_0000_0000_0001, 8'hFF, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_val", pkt_tx_val, 0);
    chk("mrst_sop", pkt_tx_sop, 0);
    chk("mrst_data", pkt_tx_data, 0);
    chk("mrst_pkt_cnt", pkt_cnt, 0);
    chk("mrst_keep_err", keep_err_cnt, 0);
    chk("mrst_ready", s_ready, 0);
    idle(2);
    rst = 1'b0;
    obs.delete();
    tick();
    push_beat(64'hB000_0000_0000_0042, 8'hFF, 1'b1);
    idle(4);
    chk("after_rst_words", obs.size(), 1);
    if (obs.size() == 1) begin
      chk("after_rst_data", obs[0].d, 64'hB000_0000_0000_0042);
      chk("after_rst_sop", obs[0].sop, 1);
      chk("after_rst_eop", obs[0].eop, 1);
      chk("after_rst_mod", obs[0].mod, 0);
    end
    chk("after_rst_pkt_cnt", pkt_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
